// File: rtl/imem_fetch_sequencer_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_fetch_sequencer_pkg;

  // Fetch controller states: IDLE waits for Enable, FETCH holds the address
  // on the memory and counts down the read latency.
  typedef enum logic [0:0] {
    FS_IDLE  = 1'b0,
    FS_FETCH = 1'b1
  } fetch_state_t;

  // Every LEGv8 instruction is one 32-bit word.
  localparam int INSTR_BYTES = 4;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/imem_fetch_sequencer_fetch_queue.sv
// Small synchronous FIFO holding {PC, instr} entries between fetch and decode.
// Latency: a push is visible at the head right after its edge; the head is read combinationally.
// Backpressure: a push is dropped when full unless a pop happens on the same edge; flush wins over both.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_push, i_dat           write request and data
//   i_pop                   remove head (ignored when empty)
//   i_flush                 reset pointers/count, storage left as is
//   o_dat                   head entry
//   o_full, o_empty, o_count occupancy status
module fetch_queue #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_dat,
  output logic [WIDTH-1:0]           o_dat,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dat     = r_mem[r_rd_ptr];

  // A full queue still accepts a push when the head leaves on the same edge.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      // Only the bookkeeping is reset; stale storage is unreachable once empty.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, holds it on the memory for RD_LATENCY cycles, queues words for decode.
// Latency: RD_LATENCY edges from fetch start to capture; Instr_Valid rises on the capture edge.
// Backpressure: a full queue without a pop stalls the fetch with the address held; Redirect_Valid flushes and restarts.
//
// Ports:
//   CLK, Reset_L                       core clock, asynchronous active-low reset
//   Enable                             allow new fetches to start
//   IMemAddress / IMemData             instruction memory address out, word in (combinational)
//   Instr_Valid / Instr_Ready          decode handshake; Instr / Instr_PC are the queue head
//   Redirect_Valid / Redirect_PC       taken branch from execute
//   Queue_Count                        queue occupancy (debug)
module imem_fetch_sequencer
  import imem_fetch_sequencer_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          RD_LATENCY = 2,
  parameter int          QDEPTH     = 2
) (
  input  logic                       CLK,
  input  logic                       Reset_L,
  input  logic                       Enable,
  output logic [63:0]                IMemAddress,
  input  logic [31:0]                IMemData,
  output logic                       Instr_Valid,
  input  logic                       Instr_Ready,
  output logic [31:0]                Instr,
  output logic [63:0]                Instr_PC,
  input  logic                       Redirect_Valid,
  input  logic [63:0]                Redirect_PC,
  output logic [$clog2(QDEPTH):0]    Queue_Count
);

  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(RD_LATENCY - 1);

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  logic [63:0]  r_pc;
  logic [63:0]  w_next_pc;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_next_cnt;

  logic        w_pop;
  logic        w_cap_due;
  logic        w_cap;
  logic        w_q_full;
  logic        w_q_empty;
  logic [95:0] w_q_rdat;
  logic [63:0] w_redirect_pc;

  assign IMemAddress   = r_pc;
  assign Instr_Valid   = ~w_q_empty;
  assign Instr         = w_q_rdat[31:0];
  assign Instr_PC      = w_q_rdat[95:32];

  // Branch targets are always word aligned; the low bits are dropped.
  assign w_redirect_pc = Redirect_PC & ~64'h3;

  assign w_pop     = Instr_Valid & Instr_Ready;
  assign w_cap_due = (r_state == FS_FETCH) && (r_cnt == '0);
  // Capture needs a free slot, or one freed by a pop on this same edge.
  assign w_cap     = w_cap_due & (~w_q_full | w_pop);

  fetch_queue #(
    .WIDTH (96),
    .DEPTH (QDEPTH)
  ) u_fetch_queue (
    .i_clk   (CLK),
    .i_rst_n (Reset_L),
    .i_push  (w_cap & ~Redirect_Valid),
    .i_pop   (w_pop & ~Redirect_Valid),
    .i_flush (Redirect_Valid),
    .i_dat   ({r_pc, IMemData}),
    .o_dat   (w_q_rdat),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (Queue_Count)
  );

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state <= FS_IDLE;
      r_pc    <= RESET_PC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_cnt   = r_cnt;

    if (Redirect_Valid) begin
      // Redirect overrides any capture or countdown on this edge.
      w_next_pc = w_redirect_pc;
      if (r_state == FS_FETCH) begin
        if (Enable) begin
          w_next_cnt = CNT_RELOAD;
        end else begin
          w_next_state = FS_IDLE;
          w_next_cnt   = '0;
        end
      end
    end else begin
      case (r_state)
        FS_IDLE: begin
          if (Enable) begin
            w_next_state = FS_FETCH;
            w_next_cnt   = CNT_RELOAD;
          end
        end
        FS_FETCH: begin
          if (r_cnt != '0) begin
            w_next_cnt = r_cnt - 1'b1;
          end else if (w_cap) begin
            w_next_pc = r_pc + 64'(INSTR_BYTES);
            if (Enable) begin
              w_next_cnt = CNT_RELOAD;
            end else begin
              w_next_state = FS_IDLE;
            end
          end
          // Otherwise stalled on a full queue: counter stays 0, address held.
        end
        default: begin
          w_next_state = FS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Self-checking bench for imem_fetch_sequencer: directed scenarios plus randomized traffic against a queue-based model.
// Latency: n/a.
// Backpressure: Instr_Ready is driven randomly in the random phase.
module tb_imem_fetch_sequencer;

  localparam int          RDL = 2;
  localparam int          QD  = 2;
  localparam logic [63:0] RPC = 64'h0;

  logic        CLK;
  logic        Reset_L;
  logic        Enable;
  logic [63:0] IMemAddress;
  logic [31:0] IMemData;
  logic        Instr_Valid;
  logic        Instr_Ready;
  logic [31:0] Instr;
  logic [63:0] Instr_PC;
  logic        Redirect_Valid;
  logic [63:0] Redirect_PC;
  logic [$clog2(QD):0] Queue_Count;

  imem_fetch_sequencer #(
    .RESET_PC   (RPC),
    .RD_LATENCY (RDL),
    .QDEPTH     (QD)
  ) dut (
    .CLK            (CLK),
    .Reset_L        (Reset_L),
    .Enable         (Enable),
    .IMemAddress    (IMemAddress),
    .IMemData       (IMemData),
    .Instr_Valid    (Instr_Valid),
    .Instr_Ready    (Instr_Ready),
    .Instr          (Instr),
    .Instr_PC       (Instr_PC),
    .Redirect_Valid (Redirect_Valid),
    .Redirect_PC    (Redirect_PC),
    .Queue_Count    (Queue_Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory: the test program at 0x000..0x010, a address-derived pattern elsewhere.
  logic [31:0] prog [5] = '{32'h910003E1, 32'h910007E2, 32'h8B020021, 32'h8B020022, 32'h16000002};

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a < 64'h14) return prog[a[4:2]];
    return a[31:0] ^ 32'hC0DE_0001;
  endfunction

  assign IMemData = mem_word(IMemAddress);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_busy: a fetch is in progress; m_wait: edges still to pass before the capture edge.
  logic [63:0] m_pc;
  bit          m_busy;
  int          m_wait;
  logic [95:0] m_q[$];

  task automatic model_reset();
    m_pc   = RPC;
    m_busy = 0;
    m_wait = 0;
    m_q.delete();
  endtask

  task automatic model_edge(input logic en, input logic rdy, input logic rv, input logic [63:0] rpc);
    bit pop;
    bit room;
    pop = (m_q.size() > 0) && rdy;
    if (rv) begin
      m_q.delete();
      m_pc = {rpc[63:2], 2'b00};
      if (m_busy) begin
        if (en) m_wait = RDL - 1;
        else    m_busy = 0;
      end
      return;
    end
    if (!m_busy) begin
      if (pop) void'(m_q.pop_front());
      if (en) begin
        m_busy = 1;
        m_wait = RDL - 1;
      end
      return;
    end
    if (m_wait > 0) begin
      if (pop) void'(m_q.pop_front());
      m_wait--;
      return;
    end
    room = (m_q.size() < QD) || pop;
    if (pop) void'(m_q.pop_front());
    if (room) begin
      m_q.push_back({m_pc, mem_word(m_pc)});
      m_pc = m_pc + 64'd4;
      if (en) m_wait = RDL - 1;
      else    m_busy = 0;
    end
  endtask

  task automatic compare_all();
    check_eq("valid", Instr_Valid, m_q.size() > 0);
    check_eq("count", Queue_Count, m_q.size());
    check_eq("addr", IMemAddress, m_pc);
    if (m_q.size() > 0) begin
      check_eq("instr", Instr, m_q[0][31:0]);
      check_eq("instr_pc", Instr_PC, m_q[0][95:32]);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  logic [95:0] got_q[$];
  int          edge_no;

  // Called at a falling edge: drive inputs, step the model, let one rising edge pass, compare.
  task automatic cyc(input logic en, input logic rdy, input logic rv, input logic [63:0] rpc);
    Enable         = en;
    Instr_Ready    = rdy;
    Redirect_Valid = rv;
    Redirect_PC    = rpc;
    if (Instr_Valid && rdy && !rv) got_q.push_back({Instr_PC, Instr});
    model_edge(en, rdy, rv, rpc);
    @(posedge CLK);
    edge_no++;
    @(negedge CLK);
    compare_all();
  endtask

  task automatic do_reset();
    Reset_L        = 1'b0;
    Enable         = 1'b0;
    Instr_Ready    = 1'b0;
    Redirect_Valid = 1'b0;
    Redirect_PC    = '0;
    @(posedge CLK);
    @(negedge CLK);
    model_reset();
    Reset_L = 1'b1;
    got_q.delete();
    edge_no = 0;
  endtask

  logic [63:0] exp_pc [5] = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10};

  initial begin
    int first_valid;
    int last_v;
    Reset_L        = 1'b0;
    Enable         = 1'b0;
    Instr_Ready    = 1'b0;
    Redirect_Valid = 1'b0;
    Redirect_PC    = '0;
    repeat (2) @(negedge CLK);
    check_eq("rst_valid", Instr_Valid, 0);
    check_eq("rst_instr", Instr, 0);
    check_eq("rst_instr_pc", Instr_PC, 0);
    check_eq("rst_count", Queue_Count, 0);
    check_eq("rst_addr", IMemAddress, RPC);
    model_reset();
    Reset_L = 1'b1;
    edge_no = 0;

    // Program streams through with Ready held high.
    first_valid = -1;
    last_v      = -1;
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, 0, 0);
      if (Instr_Valid) begin
        if (first_valid < 0) first_valid = edge_no;
        else check_eq("valid_gap", edge_no - last_v, 2);
        last_v = edge_no;
      end
    end
    check_eq("first_valid_edge", first_valid, 3);
    check_eq("t1_npop", got_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) begin
        check_eq("t1_pc", got_q[i][95:32], exp_pc[i]);
        check_eq("t1_instr", got_q[i][31:0], prog[i]);
      end
    end

    // Decode stalls for 10 cycles, then drains.
    do_reset();
    repeat (10) cyc(1, 0, 0, 0);
    check_eq("t2_count_full", Queue_Count, 2);
    check_eq("t2_addr_held", IMemAddress, 64'h8);
    repeat (8) cyc(1, 1, 0, 0);
    check_eq("t2_npop_ge4", got_q.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        check_eq("t2_pc", got_q[i][95:32], exp_pc[i]);
        check_eq("t2_instr", got_q[i][31:0], prog[i]);
      end
    end

    // Redirect to 0x003 on the edge that would capture PC 0x008.
    do_reset();
    repeat (6) cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 64'h3);
    check_eq("t3_count", Queue_Count, 0);
    check_eq("t3_valid", Instr_Valid, 0);
    check_eq("t3_addr", IMemAddress, 64'h0);
    repeat (2) cyc(1, 1, 0, 0);
    check_eq("t3_head_valid", Instr_Valid, 1);
    check_eq("t3_head_pc", Instr_PC, 64'h0);
    check_eq("t3_head_instr", Instr, 32'h910003E1);

    // Redirect and pop together with a full queue.
    do_reset();
    repeat (8) cyc(1, 0, 0, 0);
    check_eq("t4_full", Queue_Count, 2);
    cyc(1, 1, 1, 64'h10);
    check_eq("t4_count", Queue_Count, 0);
    check_eq("t4_valid", Instr_Valid, 0);
    check_eq("t4_no_pop", got_q.size(), 0);
    repeat (2) cyc(1, 1, 0, 0);
    check_eq("t4_head_valid", Instr_Valid, 1);
    check_eq("t4_head_pc", Instr_PC, 64'h10);
    check_eq("t4_head_instr", Instr, 32'h16000002);

    // Enable drops while PC 0x004 is being fetched.
    do_reset();
    repeat (3) cyc(1, 1, 0, 0);
    repeat (5) cyc(0, 1, 0, 0);
    check_eq("t5_addr_idle", IMemAddress, 64'h8);
    check_eq("t5_npop", got_q.size(), 2);
    if (got_q.size() == 2) check_eq("t5_pc4", got_q[1][95:32], 64'h4);
    repeat (3) cyc(1, 1, 0, 0);
    check_eq("t5_resume_valid", Instr_Valid, 1);
    check_eq("t5_resume_pc", Instr_PC, 64'h8);

    // Asynchronous reset between edges, in the middle of a fetch.
    do_reset();
    repeat (4) cyc(1, 1, 0, 0);
    #2;
    Reset_L = 1'b0;
    #1;
    check_eq("t6_valid", Instr_Valid, 0);
    check_eq("t6_addr", IMemAddress, RPC);
    check_eq("t6_count", Queue_Count, 0);
    model_reset();
    @(negedge CLK);
    Reset_L = 1'b1;
    edge_no = 0;
    got_q.delete();
    repeat (3) cyc(1, 1, 0, 0);
    check_eq("t6_restart_valid", Instr_Valid, 1);
    check_eq("t6_restart_pc", Instr_PC, 64'h0);

    // Randomized traffic, including redirects near the top of the address space.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        en;
      logic        rdy;
      logic        rv;
      logic [63:0] rpc;
      en  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 2))
        0:       rpc = {$urandom, $urandom};
        1:       rpc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
        default: rpc = 64'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 499) == 0) do_reset();
      else cyc(en, rdy, rv, rpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
